// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Produces {remainder, quotient} one quotient bit per cycle; abortable by flush/annul.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_div_i,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_e;

    localparam int CW = $clog2(WIDTH + 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 ready_q, ready_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH+1:0]     diff;
    logic                 fit;
    logic [WIDTH-1:0]     rem_step, quo_step, quo_fix, rem_fix;

    always_comb begin
        abs_a    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs_b    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        // Extra guard bit: the shifted remainder can exceed WIDTH bits when the divisor's MSB is set.
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        diff     = {1'b0, rem_sh} - {2'b00, dvs_q};
        fit      = ~diff[WIDTH+1];
        rem_step = fit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], fit};
        quo_fix  = neg_quo_q ? -quo_step : quo_step;
        rem_fix  = neg_rem_q ? -rem_step : rem_step;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        ready_d   = ready_q;
        result_d  = result_q;

        if (flush || annul_i) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            rem_d    = '0;
            quo_d    = '0;
            ready_d  = 1'b0;
            result_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (opdata2_i == '0) begin
                            state_d = S_DIVZERO;
                        end else begin
                            state_d   = S_ON;
                            cnt_d     = '0;
                            rem_d     = '0;
                            quo_d     = abs_a;
                            dvs_d     = abs_b;
                            neg_quo_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            neg_rem_d = signed_div_i && opdata1_i[WIDTH-1];
                        end
                    end
                end
                S_DIVZERO: begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = '0;
                end
                S_ON: begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = S_END;
                        ready_d  = 1'b1;
                        result_d = {rem_fix, quo_fix};
                    end
                end
                S_END: begin
                    // Result is held while the ALU keeps start_i high.
                    if (!start_i) begin
                        state_d  = S_IDLE;
                        ready_d  = 1'b0;
                        result_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_radix2.sv
// Randomized self-checking bench for div_radix2 against an arithmetic reference model.
module tb_div_radix2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic        signed_div = 1'b0;
    logic        ready_o;
    logic [63:0] result_o;

    int vectors = 0;
    int errors  = 0;

    div_radix2 #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .opdata1_i(opdata1), .opdata2_i(opdata2),
        .start_i(start), .annul_i(annul), .signed_div_i(signed_div),
        .ready_o(ready_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    // Truncating division done in 64-bit arithmetic so the -2^31 / -1 case wraps naturally.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sg);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Drives one request; reports latency (edges from start edge, -1 on timeout), result, and
    // whether result_o was nonzero while ready_o was low.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit sg, input bit scr,
                         output int lat, output logic [63:0] res, output bit leak);
        opdata1 = a; opdata2 = b; signed_div = sg; start = 1'b1;
        lat = -1; res = '0; leak = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); @(negedge clk);
            if (ready_o) begin lat = n; res = result_o; break; end
            if (result_o !== 64'd0) leak = 1'b1;
            if (scr) begin opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom); end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready_o); end
        vectors++; if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", result_o); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [31:0] ta [5] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] tb [5] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1};
        bit          ts [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] te [5] = '{{32'd2, 32'd14}, {32'hFFFFFFFF, 32'hFFFFFFFD}, {32'd1, 32'hFFFFFFFD},
                                {32'd0, 32'h80000000}, {32'd0, 32'hFFFFFFFF}};
        int lat; logic [63:0] res; bit leak;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], ts[i], 1'b0, lat, res, leak);
            vectors++; if (lat != 33) begin errors++; $display("FAIL directed_latency[%0d] got %0d want 33", i, lat); end
            vectors++; if (res !== te[i]) begin errors++; $display("FAIL directed_result[%0d] got %h want %h", i, res, te[i]); end
            vectors++; if (leak) begin errors++; $display("FAIL directed_zero_before_ready[%0d] got nonzero want 0", i); end
            @(posedge clk); @(negedge clk);
            vectors++; if (ready_o !== 1'b0 || result_o !== 64'd0) begin
                errors++; $display("FAIL directed_pulse[%0d] got ready=%b result=%h want 0/0", i, ready_o, result_o);
            end
        end
    endtask

    task automatic test_divzero;
        int lat; logic [63:0] res; bit leak;
        do_op(32'd5, 32'd0, 1'b1, 1'b0, lat, res, leak);
        vectors++; if (lat != 2) begin errors++; $display("FAIL divzero_latency got %0d want 2", lat); end
        vectors++; if (res !== 64'd0) begin errors++; $display("FAIL divzero_result got %h want 0", res); end
        @(posedge clk); @(negedge clk);
        vectors++; if (ready_o !== 1'b0) begin errors++; $display("FAIL divzero_pulse got %b want 0", ready_o); end
    endtask

    task automatic test_random(input bit scr);
        int lat; logic [63:0] res, exp; bit leak;
        logic [31:0] a, b; bit sg;
        for (int i = 0; i < 20; i++) begin
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (i % 4 == 1) b = -b;
            sg = 1'($urandom);
            exp = ref_div(a, b, sg);
            do_op(a, b, sg, scr, lat, res, leak);
            vectors++; if (lat != (b == 0 ? 2 : 33)) begin errors++; $display("FAIL random_latency[%0d] got %0d", i, lat); end
            vectors++; if (res !== exp) begin
                errors++; $display("FAIL random_result[%0d] scr=%0d a=%h b=%h s=%0d got %h want %h", i, scr, a, b, sg, res, exp);
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    // kind: 0 = flush, 1 = annul, 2 = reset
    task automatic test_abort(input int kind);
        int lat; logic [63:0] res; bit leak, seen;
        opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (kind == 0) flush = 1'b1; else if (kind == 1) annul = 1'b1; else rst = 1'b0;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; annul = 1'b0; rst = 1'b1;
        vectors++; if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++; $display("FAIL abort%0d_clear got ready=%b result=%h want 0/0", kind, ready_o, result_o);
        end
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin @(negedge clk); if (ready_o) seen = 1'b1; end
        vectors++; if (seen) begin errors++; $display("FAIL abort%0d_no_ready got ready pulse want none", kind); end
        do_op(32'd9, 32'd3, 1'b0, 1'b0, lat, res, leak);
        vectors++; if (lat != 33 || res !== {32'd0, 32'd3}) begin
            errors++; $display("FAIL abort%0d_restart got lat=%0d res=%h want 33/%h", kind, lat, res, {32'd0, 32'd3});
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_flush_at_start;
        int lat; logic [63:0] res; bit leak;
        opdata1 = 32'd50; opdata2 = 32'd5; signed_div = 1'b0; start = 1'b1; flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        do_op(32'd50, 32'd5, 1'b0, 1'b0, lat, res, leak);
        vectors++; if (lat != 33 || res !== {32'd0, 32'd10}) begin
            errors++; $display("FAIL flush_at_start got lat=%0d res=%h want 33/%h", lat, res, {32'd0, 32'd10});
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_hold;
        int lat; logic [63:0] res, exp; bit leak, bad;
        exp = ref_div(32'hFFFFFF9C, 32'd9, 1'b1);
        do_op(32'hFFFFFF9C, 32'd9, 1'b1, 1'b0, lat, res, leak);
        start = 1'b1;
        bad = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); @(negedge clk);
            if (ready_o !== 1'b1 || result_o !== exp) bad = 1'b1;
        end
        vectors++; if (bad || res !== exp) begin errors++; $display("FAIL hold_stable got res=%h want %h held", res, exp); end
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        vectors++; if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++; $display("FAIL hold_release got ready=%b result=%h want 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2; logic [63:0] r1, r2; bit leak;
        do_op(32'd1234567, 32'd89, 1'b0, 1'b0, lat1, r1, leak);
        @(posedge clk); @(negedge clk);
        do_op(32'hFFFF0000, 32'd77, 1'b1, 1'b0, lat2, r2, leak);
        vectors++; if (lat1 != 33 || r1 !== ref_div(32'd1234567, 32'd89, 1'b0)) begin
            errors++; $display("FAIL b2b_first got lat=%0d res=%h", lat1, r1);
        end
        vectors++; if (lat2 != 33 || r2 !== ref_div(32'hFFFF0000, 32'd77, 1'b1)) begin
            errors++; $display("FAIL b2b_second got lat=%0d res=%h", lat2, r2);
        end
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_divzero();
        test_random(1'b0);
        test_abort(0);
        test_abort(1);
        test_abort(2);
        test_flush_at_start();
        test_hold();
        test_random(1'b1);
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
